// File: rtl/fetch_pc_unit_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | fetch_pc_unit_if : redirect inputs, instruction-memory bus, decode port |
// | Revision 1.0                                                            |
// +------------------------------------------------------------------------+
interface fetch_pc_unit_if #(
   parameter int WIDTH = 32
);
   logic [1:0]       pc_src;
   logic             branch_valid;
   logic [WIDTH-1:0] target;
   logic [WIDTH-1:0] sepc;
   logic [WIDTH-1:0] mepc;
   logic             trap_taken;
   logic [WIDTH-1:0] trap_addr;
   logic             inst_mem_rd_en;
   logic [WIDTH-1:0] inst_mem_addr;
   logic             inst_mem_ack;
   logic [31:0]      inst_mem_data;
   logic             inst_valid;
   logic             inst_ready;
   logic [31:0]      inst;
   logic [WIDTH-1:0] inst_pc;

   // master: the fetch unit itself
   modport master (
      input  pc_src, branch_valid, target, sepc, mepc, trap_taken, trap_addr,
      input  inst_mem_ack, inst_mem_data, inst_ready,
      output inst_mem_rd_en, inst_mem_addr, inst_valid, inst, inst_pc
   );

   // slave: branch logic, instruction memory and decode around it
   modport slave (
      output pc_src, branch_valid, target, sepc, mepc, trap_taken, trap_addr,
      output inst_mem_ack, inst_mem_data, inst_ready,
      input  inst_mem_rd_en, inst_mem_addr, inst_valid, inst, inst_pc
   );
endinterface
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | fetch_pc_unit : PC register and single-outstanding fetch sequencer      |
// | Revision 1.0                                                            |
// +------------------------------------------------------------------------+
module fetch_pc_unit #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input wire logic        clock,
   input wire logic        reset_n,
   fetch_pc_unit_if.master bus
);
   typedef enum logic [1:0] {BOOT, FETCH, HOLD, DRAIN} state_t;

   localparam logic [WIDTH-1:0] C_TARGET_MASK = {{(WIDTH-1){1'b1}}, 1'b0};

   state_t           r_state;
   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] r_addr;
   logic             r_rdEn;
   logic             r_valid;
   logic [31:0]      r_inst;
   logic [WIDTH-1:0] r_instPc;

   logic             w_redirect;
   logic [WIDTH-1:0] w_newPc;
   logic [WIDTH-1:0] w_pcNext;
   logic [WIDTH-1:0] w_holdNext;

   always_comb begin
      w_redirect = bus.trap_taken | (bus.branch_valid & (bus.pc_src != 2'b00));
      w_newPc    = r_pc;
      if (bus.trap_taken) begin
         w_newPc = bus.trap_addr;
      end else begin
         case (bus.pc_src)
            2'b01:   w_newPc = bus.sepc;
            2'b10:   w_newPc = bus.mepc;
            2'b11:   w_newPc = bus.target & C_TARGET_MASK;
            default: w_newPc = r_pc;
         endcase
      end
      w_pcNext   = w_redirect ? w_newPc : r_pc;
      w_holdNext = w_redirect ? w_newPc : (r_pc + WIDTH'(4));
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= BOOT;
         r_pc     <= RESET_PC;
         r_addr   <= RESET_PC;
         r_rdEn   <= 1'b0;
         r_valid  <= 1'b0;
         r_inst   <= '0;
         r_instPc <= RESET_PC;
      end else begin
         case (r_state)
            BOOT: begin
               r_pc    <= w_pcNext;
               r_addr  <= w_pcNext;
               r_rdEn  <= 1'b1;
               r_state <= FETCH;
            end
            FETCH: begin
               if (bus.inst_mem_ack) begin
                  if (w_redirect) begin
                     // Returned word belongs to the abandoned path; reissue at once
                     r_pc   <= w_newPc;
                     r_addr <= w_newPc;
                  end else begin
                     r_inst   <= bus.inst_mem_data;
                     r_instPc <= r_pc;
                     r_valid  <= 1'b1;
                     r_rdEn   <= 1'b0;
                     r_state  <= HOLD;
                  end
               end else if (w_redirect) begin
                  r_pc    <= w_newPc;
                  r_state <= DRAIN;
               end
            end
            DRAIN: begin
               // Old request must complete before the redirected one may issue
               r_pc <= w_pcNext;
               if (bus.inst_mem_ack) begin
                  r_addr  <= w_pcNext;
                  r_state <= FETCH;
               end
            end
            HOLD: begin
               if (w_redirect || bus.inst_ready) begin
                  r_valid <= 1'b0;
                  r_pc    <= w_holdNext;
                  r_addr  <= w_holdNext;
                  r_rdEn  <= 1'b1;
                  r_state <= FETCH;
               end
            end
            default: r_state <= BOOT;
         endcase
      end
   end

   assign bus.inst_mem_rd_en = r_rdEn;
   assign bus.inst_mem_addr  = r_addr;
   assign bus.inst_valid     = r_valid;
   assign bus.inst           = r_inst;
   assign bus.inst_pc        = r_instPc;
endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// Bench for fetch_pc_unit: directed vector table, hand-written corner sequences,
// then randomized traffic against a transaction-level model.
module tb_fetch_pc_unit;
   logic clock;
   logic reset_n;
   int   checks = 0;
   int   passes = 0;

   fetch_pc_unit_if #(.WIDTH(32)) bus ();

   fetch_pc_unit #(.WIDTH(32), .RESET_PC(32'h0)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        ack;
      logic [31:0] data;
      logic        ready;
      logic        bv;
      logic [1:0]  src;
      logic [31:0] tgt;
      logic        eRd;
      logic [31:0] eAddr;
      logic        eValid;
      logic [31:0] eInst;
      logic [31:0] ePc;
   } vec_t;

   vec_t vecs[9];

   // Reference model state
   logic        mBoot, mReqOn, mStale, mValid;
   logic [31:0] mPc, mReqAddr, mInst, mInstPc;
   int          memCnt, memLat;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic setIdle();
      bus.pc_src        = 2'b00;
      bus.branch_valid  = 1'b0;
      bus.target        = '0;
      bus.sepc          = '0;
      bus.mepc          = '0;
      bus.trap_taken    = 1'b0;
      bus.trap_addr     = '0;
      bus.inst_mem_ack  = 1'b0;
      bus.inst_mem_data = '0;
      bus.inst_ready    = 1'b0;
   endtask

   task automatic checkOut(input string name, input logic eRd, input logic [31:0] eAddr,
                           input logic eValid, input logic [31:0] eInst, input logic [31:0] ePc);
      bit ok;
      ok = (bus.inst_mem_rd_en === eRd) && (!eRd || bus.inst_mem_addr === eAddr) &&
           (bus.inst_valid === eValid) &&
           (!eValid || (bus.inst === eInst && bus.inst_pc === ePc));
      checks++;
      if (ok) passes++;
      else $display("FAIL %s: got rd=%0b addr=%h v=%0b inst=%h pc=%h, want rd=%0b addr=%h v=%0b inst=%h pc=%h",
                    name, bus.inst_mem_rd_en, bus.inst_mem_addr, bus.inst_valid, bus.inst, bus.inst_pc,
                    eRd, eAddr, eValid, eInst, ePc);
   endtask

   task automatic checkReset(input string name);
      bit ok;
      ok = (bus.inst_mem_rd_en === 1'b0) && (bus.inst_mem_addr === 32'h0) &&
           (bus.inst_valid === 1'b0) && (bus.inst === 32'h0) && (bus.inst_pc === 32'h0);
      checks++;
      if (ok) passes++;
      else $display("FAIL %s: got rd=%0b addr=%h v=%0b inst=%h pc=%h, want all reset values",
                    name, bus.inst_mem_rd_en, bus.inst_mem_addr, bus.inst_valid, bus.inst, bus.inst_pc);
   endtask

   function automatic logic [31:0] refNewPc();
      if (bus.trap_taken) return bus.trap_addr;
      case (bus.pc_src)
         2'b01:   return bus.sepc;
         2'b10:   return bus.mepc;
         default: return {bus.target[31:1], 1'b0};
      endcase
   endfunction

   // Advance the model by one clock using the inputs currently driven.
   task automatic modelStep();
      logic        redir;
      logic [31:0] np;
      redir = bus.trap_taken || (bus.branch_valid && bus.pc_src != 2'b00);
      np    = refNewPc();
      if (mBoot) begin
         mBoot = 0; mReqOn = 1; mReqAddr = mPc;
      end else if (mValid) begin
         if (redir) begin
            mValid = 0; mPc = np; mReqOn = 1; mReqAddr = np;
         end else if (bus.inst_ready) begin
            mValid = 0; mPc = mPc + 32'd4; mReqOn = 1; mReqAddr = mPc;
         end
      end else if (mReqOn) begin
         if (redir) mPc = np;
         if (bus.inst_mem_ack) begin
            if (mStale || redir) begin
               mStale = 0; mReqAddr = mPc;
            end else begin
               mValid = 1; mInst = bus.inst_mem_data; mInstPc = mReqAddr; mReqOn = 0;
            end
         end else if (redir) begin
            mStale = 1;
         end
      end
   endtask

   initial begin
      vecs[0] = '{1'b0, 32'h0,   1'b0, 1'b0, 2'b00, 32'h0,    1'b1, 32'h0,    1'b0, 32'h0,   32'h0};
      vecs[1] = '{1'b1, 32'h13,  1'b0, 1'b0, 2'b00, 32'h0,    1'b0, 32'h0,    1'b1, 32'h13,  32'h0};
      vecs[2] = '{1'b0, 32'h0,   1'b1, 1'b0, 2'b00, 32'h0,    1'b1, 32'h4,    1'b0, 32'h0,   32'h0};
      vecs[3] = '{1'b1, 32'h93,  1'b1, 1'b0, 2'b00, 32'h0,    1'b0, 32'h0,    1'b1, 32'h93,  32'h4};
      vecs[4] = '{1'b0, 32'h0,   1'b1, 1'b0, 2'b00, 32'h0,    1'b1, 32'h8,    1'b0, 32'h0,   32'h0};
      vecs[5] = '{1'b1, 32'h113, 1'b0, 1'b0, 2'b00, 32'h0,    1'b0, 32'h0,    1'b1, 32'h113, 32'h8};
      vecs[6] = '{1'b0, 32'h0,   1'b0, 1'b1, 2'b11, 32'h1235, 1'b1, 32'h1234, 1'b0, 32'h0,   32'h0};
      vecs[7] = '{1'b1, 32'hAB,  1'b0, 1'b0, 2'b00, 32'h0,    1'b0, 32'h0,    1'b1, 32'hAB,  32'h1234};
      vecs[8] = '{1'b0, 32'h0,   1'b1, 1'b0, 2'b00, 32'h0,    1'b1, 32'h1238, 1'b0, 32'h0,   32'h0};

      reset_n = 1'b0;
      setIdle();
      tick();
      tick();
      checkReset("reset_state");
      reset_n = 1'b1;

      // Sequential fetch followed by a jump from Hold
      for (int i = 0; i < 9; i++) begin
         setIdle();
         bus.inst_mem_ack  = vecs[i].ack;
         bus.inst_mem_data = vecs[i].data;
         bus.inst_ready    = vecs[i].ready;
         bus.branch_valid  = vecs[i].bv;
         bus.pc_src        = vecs[i].src;
         bus.target        = vecs[i].tgt;
         tick();
         checkOut($sformatf("vec%0d", i), vecs[i].eRd, vecs[i].eAddr, vecs[i].eValid,
                  vecs[i].eInst, vecs[i].ePc);
      end

      // Redirect while a request is outstanding: old request kept, its data dropped
      setIdle();
      bus.branch_valid = 1'b1; bus.pc_src = 2'b10; bus.mepc = 32'h8000_0000;
      tick();
      checkOut("drain_hold_old", 1'b1, 32'h1238, 1'b0, 32'h0, 32'h0);
      setIdle();
      tick();
      checkOut("drain_wait", 1'b1, 32'h1238, 1'b0, 32'h0, 32'h0);
      bus.inst_mem_ack = 1'b1; bus.inst_mem_data = 32'hDEAD_BEEF;
      tick();
      checkOut("drain_drop_stale", 1'b1, 32'h8000_0000, 1'b0, 32'h0, 32'h0);
      bus.inst_mem_data = 32'h55;
      tick();
      checkOut("drain_new_inst", 1'b0, 32'h0, 1'b1, 32'h55, 32'h8000_0000);

      // Trap outranks an xRET redirect
      setIdle();
      bus.trap_taken = 1'b1; bus.trap_addr = 32'h100;
      bus.branch_valid = 1'b1; bus.pc_src = 2'b01; bus.sepc = 32'h200;
      tick();
      checkOut("trap_priority", 1'b1, 32'h100, 1'b0, 32'h0, 32'h0);

      // Ack together with redirect: data discarded, new request next cycle
      setIdle();
      bus.inst_mem_ack = 1'b1; bus.inst_mem_data = 32'h1111_2222;
      bus.trap_taken = 1'b1; bus.trap_addr = 32'hFFFF_FFFC;
      tick();
      checkOut("ack_redirect", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);
      setIdle();
      bus.inst_mem_ack = 1'b1; bus.inst_mem_data = 32'h777;
      tick();
      checkOut("wrap_fetch", 1'b0, 32'h0, 1'b1, 32'h777, 32'hFFFF_FFFC);
      setIdle();
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOut($sformatf("backpressure%0d", i), 1'b0, 32'h0, 1'b1, 32'h777, 32'hFFFF_FFFC);
      end
      bus.inst_ready = 1'b1;
      tick();
      checkOut("wrap_next", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);

      // Asynchronous reset in the middle of a fetch
      setIdle();
      #2;
      reset_n = 1'b0;
      #1;
      checkReset("reset_async");
      tick();
      tick();
      reset_n = 1'b1;
      #1;
      checkReset("reset_boot");
      tick();
      checkOut("boot_first_fetch", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);

      // Randomized traffic against the model
      setIdle();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      mBoot = 1; mReqOn = 0; mStale = 0; mValid = 0;
      mPc = 32'h0; mReqAddr = 32'h0; mInst = 32'h0; mInstPc = 32'h0;
      memCnt = 0; memLat = 1;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         logic ackNow;
         if (bus.inst_mem_ack) memCnt = 0;
         ackNow = 1'b0;
         if (bus.inst_mem_rd_en) begin
            if (memCnt == 0) memLat = int'($urandom_range(1, 4));
            memCnt++;
            ackNow = (memCnt >= memLat);
         end
         setIdle();
         bus.inst_mem_ack  = ackNow;
         bus.inst_mem_data = $urandom;
         bus.inst_ready    = ($urandom_range(0, 9) < 6);
         if (!mBoot) begin
            bus.branch_valid = ($urandom_range(0, 5) == 0);
            bus.pc_src       = 2'($urandom_range(0, 3));
            bus.target       = $urandom;
            bus.sepc         = $urandom & 32'hFFFF_FFFC;
            bus.mepc         = $urandom & 32'hFFFF_FFFC;
            bus.trap_taken   = ($urandom_range(0, 29) == 0);
            bus.trap_addr    = $urandom & 32'hFFFF_FFFC;
         end
         modelStep();
         tick();
         checkOut($sformatf("rand%0d", cyc), mReqOn, mReqAddr, mValid, mInst, mInstPc);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
`default_nettype wire
